adder_share_arbiter: RTL and testbench

- Shares one adder_nbit instance between NUM_REQ requesters. Arbitration is round-robin.
- Each requester presents operands with a level request. It receives a one-cycle ack together with a registered N+1-bit sum.
- Sits between the operand sources (switch/counter logic) and the 7-segment display path. This makes one adder per display project sufficient.

---
 rtl/adder_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares a single adder_nbit between NUM_REQ requesters. Each requester
//   holds a level request. When it is served it gets a one-cycle ack
//   together with a registered N+1-bit sum.
//   Transaction sequence: IDLE (grant + operand latch) -> ISSUE (adder
//   settles) -> CAPTURE (ack/sum_valid high). This gives one result every
//   3 cycles at most.
//
//   Optional macro ARB_FIXED_PRIO_EN: when defined, arbitration is fixed
//   priority (lowest index wins) and the round-robin pointer is removed.
//   When undefined, arbitration is round-robin.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   req        level request per requester, held until ack
//   a_flat     operand A, requester i at [i*N +: N]
//   b_flat     operand B, same packing
//   ack        one-hot one-cycle pulse to the served requester
//   sum_out    registered N+1-bit sum of the served operands
//   sum_valid  one-cycle pulse coincident with ack
//   sum_id     index of the served requester (valid with sum_valid)
//   busy       high in ISSUE and CAPTURE

module adder_nbit #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_arbiter #(
    parameter int N       = 10,
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*N-1:0]      a_flat,
    input  logic [NUM_REQ*N-1:0]      b_flat,
    output logic [NUM_REQ-1:0]        ack,
    output logic [N:0]                sum_out,
    output logic                      sum_valid,
    output logic [$clog2(NUM_REQ)-1:0] sum_id,
    output logic                      busy
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int IW1  = ID_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      a_reg, b_reg;
    logic [ID_W-1:0]   gnt_id;
    logic [N:0]        add_sum;
    logic [ID_W-1:0]   start;
    logic              found;
    logic [ID_W-1:0]   pick;
    logic [IW1-1:0]    idx;

`ifdef ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [ID_W-1:0] rr_ptr;
    assign start = rr_ptr;
`endif

    // Search upward from start, wrapping modulo NUM_REQ. idx is one bit
    // wider so start+k never overflows before the wrap correction.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, start} + IW1'(k);
            if (idx >= IW1'(NUM_REQ))
                idx = idx - IW1'(NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    adder_nbit #(.N(N)) u_add (
        .a   (a_reg),
        .b   (b_reg),
        .sum (add_sum)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ISSUE) || (state == CAPTURE);
    end

    // Datapath. Operands are frozen at the grant edge, so later changes on
    // a_flat/b_flat/req cannot disturb the transaction in flight. The
    // result registers load on the ISSUE->CAPTURE edge, so ack/sum_valid
    // are high exactly while the FSM sits in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            gnt_id    <= '0;
            sum_out   <= '0;
            sum_id    <= '0;
            sum_valid <= 1'b0;
            ack       <= '0;
        end else begin
            sum_valid <= 1'b0;
            ack       <= '0;
            if (state == IDLE && found) begin
                a_reg  <= a_flat[pick*N +: N];
                b_reg  <= b_flat[pick*N +: N];
                gnt_id <= pick;
            end
            if (state == ISSUE) begin
                sum_out   <= add_sum;
                sum_id    <= gnt_id;
                sum_valid <= 1'b1;
                ack       <= NUM_REQ'(1) << gnt_id;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // The served requester drops to lowest priority for the next search.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == CAPTURE)
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
    localparam int N   = 10;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*N-1:0]   a_flat, b_flat;
    logic [NR-1:0]     ack;
    logic [N:0]        sum_out;
    logic              sum_valid;
    logic [IDW-1:0]    sum_id;
    logic              busy;

    adder_share_arbiter #(.N(N), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .ack       (ack),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_id    (sum_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int a; int b; int s;} vec_t;
    typedef struct {int id; int s;} exp_t;

    exp_t q[$];
    exp_t e;
    int   errors  = 0;
    int   checks  = 0;
    int   n_valid = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic set_op(input int id, input int a, input int b);
        a_flat[id*N +: N] = N'(a);
        b_flat[id*N +: N] = N'(b);
    endtask

    // Counts posedges until sum_valid is seen at a negedge; bounded.
    task automatic wait_valid(output int lat);
        bit done;
        lat  = 0;
        done = 0;
        while (!done) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (sum_valid) done = 1;
            else if (lat >= 12) begin
                checks++;
                errors++;
                $display("FAIL timeout: no sum_valid after %0d cycles, required within 12", lat);
                done = 1;
            end
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic serve(input int id, input int a, input int b, input int s);
        int lat;
        set_op(id, a, b);
        req[id] = 1'b1;
        q.push_back('{id, s});
        wait_valid(lat);
        chk("latency", lat, 2);
        req[id] = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every result pulse is matched against the queue.
    always @(negedge clk) begin
        if (sum_valid || ack != '0) begin
            n_valid++;
            chk("ack_onehot", int'(ack), sum_valid ? (1 << sum_id) : 0);
            chk("busy_in_capture", int'(busy), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: id %0d sum %0d, nothing expected", sum_id, sum_out);
            end else begin
                e = q.pop_front();
                chk("sum_id", int'(sum_id), e.id);
                chk("sum_out", int'(sum_out), e.s);
            end
        end
    end

    vec_t vecs[6];
    int   lat;
    int   nv0;
    int   rr_ids[5];
    int   rr_sum[5];

    initial begin
        vecs[0] = '{0, 10, 500, 510};
        vecs[1] = '{2, 1023, 1023, 2046};
        vecs[2] = '{1, 5, 6, 11};
        vecs[3] = '{3, 0, 0, 0};
        vecs[4] = '{3, 1023, 1, 1024};
        vecs[5] = '{1, 512, 511, 1023};

        rst = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sum_valid", int'(sum_valid), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_sum_out", int'(sum_out), 0);
        chk("rst_sum_id", int'(sum_id), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-requester vectors
        for (int i = 0; i < 6; i++)
            serve(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s);

        // All four requesting from a freshly reset pointer
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; @(negedge clk);
        set_op(0, 0, 1); set_op(1, 100, 200); set_op(2, 300, 150); set_op(3, 630, 300);
`ifdef ARB_FIXED_PRIO_EN
        rr_ids = '{0, 0, 0, 0, 0};
        rr_sum = '{1, 1, 1, 1, 1};
`else
        rr_ids = '{0, 1, 2, 3, 0};
        rr_sum = '{1, 300, 450, 930, 1};
`endif
        for (int i = 0; i < 5; i++) q.push_back('{rr_ids[i], rr_sum[i]});
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_valid(lat);
            chk(i == 0 ? "rr_latency" : "rr_gap", lat, i == 0 ? 2 : 3);
        end
        req = '0;
        @(negedge clk);

        // Operand change during ISSUE must not affect the result
        set_op(1, 5, 6);
        req[1] = 1'b1;
        q.push_back('{1, 11});
        @(posedge clk);
        @(negedge clk);
        set_op(1, 900, 6);
        wait_valid(lat);
        chk("stab_latency", lat, 1);
        req = '0;
        @(negedge clk);

        // Reset during ISSUE after moving the pointer past 0
        serve(1, 1, 1, 2);
        set_op(1, 50, 60);
        req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("issue_busy", int'(busy), 1);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sum_valid", int'(sum_valid), 0);
        chk("abort_ack", int'(ack), 0);
        chk("abort_sum_out", int'(sum_out), 0);
        chk("abort_sum_id", int'(sum_id), 0);
        rst = 1'b0;
        nv0 = n_valid;
        repeat (4) @(negedge clk);
        chk("abort_no_result", n_valid - nv0, 0);
        // Pointer back at 0: requester 0 beats requester 2
        set_op(0, 7, 8); set_op(2, 20, 30);
        req = 4'b0101;
        q.push_back('{0, 15});
        wait_valid(lat);
        chk("post_rst_latency", lat, 2);
        req = '0;
        @(negedge clk);
        serve(3, 100, 23, 123);

        // req dropped during ISSUE: exactly one ack, no regrant
        nv0 = n_valid;
        set_op(1, 300, 400);
        req[1] = 1'b1;
        q.push_back('{1, 700});
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        wait_valid(lat);
        chk("drop_latency", lat, 1);
        repeat (8) @(negedge clk);
        chk("drop_ack_count", n_valid - nv0, 1);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
